// File: rtl/transmitter_if.sv
// rtl/transmitter_if.sv - core-side and inter-board link signals of the transmitter
interface transmitter_if #(
    parameter int n = 18
);
    logic [n-1:0] data_in;
    logic         send;
    logic         ready;
    logic         done;
    logic         error;
    logic         wire_ack;
    logic         wire_req;
    logic [5:0]   wire_data_deliver;

    // The transmitter end: takes the datagram and ack, drives status and the link.
    modport master (
        input  data_in,
        input  send,
        input  wire_ack,
        output ready,
        output done,
        output error,
        output wire_req,
        output wire_data_deliver
    );

    // The environment end: main board core plus the remote receiver.
    modport slave (
        output data_in,
        output send,
        output wire_ack,
        input  ready,
        input  done,
        input  error,
        input  wire_req,
        input  wire_data_deliver
    );
endinterface

// File: rtl/transmitter.sv
// rtl/transmitter.sv - serialises an n-bit datagram into 6-bit chunks over a four-phase req/ack link
module transmitter #(
    parameter int n            = 18,
    parameter int SETUP_CYCLES = 4,
    parameter int TIMEOUT      = 65535
) (
    input  logic          clk,
    input  logic          rst,
    transmitter_if.master bus
);
    localparam int NUM_CHUNKS = (n + 5) / 6;
    localparam int PAD_W      = NUM_CHUNKS * 6;
    localparam int IDX_W      = $clog2(NUM_CHUNKS) + 1;
    localparam int CNT_MAX    = (SETUP_CYCLES > TIMEOUT) ? SETUP_CYCLES : TIMEOUT;
    localparam int CNT_W      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
    localparam bit               TIMEOUT_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_ACK_HI,
        WAIT_ACK_LO
    } state_t;

    state_t             state, state_n;
    logic [PAD_W-1:0]   shift_buf, shift_buf_n;
    logic [PAD_W-1:0]   padded;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
    logic               req_n;
    logic               ready_n;
    logic               done_n;
    logic               error_n;
    logic [5:0]         data_n;
    logic               ack_meta;
    logic               ack_s;

    // Zero-extend the datagram so the top chunk carries zeros above bit n-1.
    always_comb begin
        padded         = '0;
        padded[n-1:0]  = bus.data_in;
    end

    // Wait/setup counter holds at its ceiling instead of wrapping.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    // Two-flop synchroniser for the asynchronous ack from the other board.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= bus.wire_ack;
            ack_s    <= ack_meta;
        end
    end

    // Next-state and next-output logic for the handshake sequencer.
    always_comb begin
        state_n     = state;
        shift_buf_n = shift_buf;
        idx_n       = idx;
        cnt_n       = cnt_inc;
        req_n       = bus.wire_req;
        data_n      = bus.wire_data_deliver;
        done_n      = 1'b0;
        error_n     = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.send) begin
                    shift_buf_n = padded;
                    idx_n       = '0;
                    data_n      = padded[5:0];
                    state_n     = SETUP;
                end
            end

            SETUP: begin
                // Ack level is deliberately ignored here; only the count matters.
                if (cnt == SETUP_LAST) begin
                    req_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = WAIT_ACK_HI;
                end
            end

            WAIT_ACK_HI: begin
                if (ack_s) begin
                    req_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = WAIT_ACK_LO;
                end else if (TIMEOUT_EN && (cnt == TIMEOUT_LAST)) begin
                    error_n = 1'b1;
                    req_n   = 1'b0;
                    data_n  = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end

            WAIT_ACK_LO: begin
                if (!ack_s) begin
                    cnt_n = '0;
                    if (idx == LAST_IDX) begin
                        done_n  = 1'b1;
                        data_n  = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n       = idx + 1'b1;
                        shift_buf_n = shift_buf >> 6;
                        data_n      = shift_buf_n[5:0];
                        state_n     = SETUP;
                    end
                end else if (TIMEOUT_EN && (cnt == TIMEOUT_LAST)) begin
                    error_n = 1'b1;
                    req_n   = 1'b0;
                    data_n  = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end

            default: begin
                req_n   = 1'b0;
                data_n  = '0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        ready_n = (state_n == IDLE);
    end

    // State, datapath and registered outputs; reset drops req at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            shift_buf             <= '0;
            idx                   <= '0;
            cnt                   <= '0;
            bus.wire_req          <= 1'b0;
            bus.wire_data_deliver <= '0;
            bus.ready             <= 1'b1;
            bus.done              <= 1'b0;
            bus.error             <= 1'b0;
        end else begin
            state                 <= state_n;
            shift_buf             <= shift_buf_n;
            idx                   <= idx_n;
            cnt                   <= cnt_n;
            bus.wire_req          <= req_n;
            bus.wire_data_deliver <= data_n;
            bus.ready             <= ready_n;
            bus.done              <= done_n;
            bus.error             <= error_n;
        end
    end
endmodule

// File: tb/tb_transmitter.sv
// tb/tb_transmitter.sv - directed self-checking bench for transmitter
module tb_transmitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    transmitter_if #(.n(18)) bus18 ();
    transmitter_if #(.n(20)) bus20 ();

    transmitter #(.n(18), .SETUP_CYCLES(4), .TIMEOUT(50)) dut18 (
        .clk (clk),
        .rst (rst),
        .bus (bus18)
    );

    transmitter #(.n(20), .SETUP_CYCLES(4), .TIMEOUT(50)) dut20 (
        .clk (clk),
        .rst (rst),
        .bus (bus20)
    );

    int checks   = 0;
    int failures = 0;

    // Remote receiver model: ack follows req three cycles later.
    logic       ack_en = 1'b1;
    logic [2:0] pipe18 = '0;
    logic [2:0] pipe20 = '0;
    always @(posedge clk) begin
        pipe18 <= {pipe18[1:0], bus18.wire_req};
        pipe20 <= {pipe20[1:0], bus20.wire_req};
    end
    assign bus18.wire_ack = ack_en & pipe18[2];
    assign bus20.wire_ack = pipe20[2];

    // Link monitors: capture the chunk on each req rise, count pulses and violations.
    logic [5:0] q18[$];
    logic [5:0] q20[$];
    logic [5:0] exp_q[$];
    logic [5:0] held18     = '0;
    logic       prev_req18 = 1'b0;
    logic       prev_req20 = 1'b0;
    int done18 = 0, err18 = 0, unstable18 = 0, ackviol18 = 0, done20 = 0;

    always @(negedge clk) begin
        if (bus18.wire_req && !prev_req18) begin
            q18.push_back(bus18.wire_data_deliver);
            held18 = bus18.wire_data_deliver;
            if (bus18.wire_ack) ackviol18++;
        end else if (bus18.wire_req && (bus18.wire_data_deliver != held18)) begin
            unstable18++;
        end
        if (bus18.done)  done18++;
        if (bus18.error) err18++;
        prev_req18 = bus18.wire_req;

        if (bus20.wire_req && !prev_req20) q20.push_back(bus20.wire_data_deliver);
        if (bus20.done) done20++;
        prev_req20 = bus20.wire_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_chunks(input string tag, input logic [5:0] got[$], input logic [5:0] exp[$]);
        check({tag, " count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check($sformatf("%s[%0d]", tag, i), {26'b0, got[i]}, {26'b0, exp[i]});
        end
    endtask

    task automatic start18(input logic [17:0] d);
        @(negedge clk);
        bus18.data_in = d;
        bus18.send    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus18.send    = 1'b0;
    endtask

    task automatic wait_done18(input string tag);
        int k = 0;
        while (!bus18.done && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, " done reached"}, bus18.done, 1'b1);
    endtask

    task automatic wait_chunks18(input int count, input string tag);
        int k = 0;
        while (q18.size() < count && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, " chunk reached"}, q18.size() >= count, 1'b1);
    endtask

    initial begin
        int lat;
        int k;

        bus18.data_in = '0;
        bus18.send    = 1'b0;
        bus20.data_in = '0;
        bus20.send    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst ready", bus18.ready, 1'b1);
        check("rst req", bus18.wire_req, 1'b0);
        check("rst data", bus18.wire_data_deliver, 6'h00);
        check("rst done", bus18.done, 1'b0);
        check("rst error", bus18.error, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal n=18
        q18.delete();
        done18 = 0;
        start18(18'h2A5C3);
        check("nom ready drops", bus18.ready, 1'b0);
        lat = 0;
        while (!bus18.wire_req && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("nom send-to-req latency", lat, 5);
        wait_done18("nom");
        @(negedge clk);
        exp_q = {6'h03, 6'h17, 6'h2A};
        check_chunks("nom chunks", q18, exp_q);
        check("nom done pulses", done18, 1);
        check("nom ready after", bus18.ready, 1'b1);
        check("nom data idle", bus18.wire_data_deliver, 6'h00);

        // Padding n=20
        @(negedge clk);
        bus20.data_in = 20'hFFFFF;
        bus20.send    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus20.send    = 1'b0;
        k = 0;
        while (!bus20.done && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("pad done reached", bus20.done, 1'b1);
        @(negedge clk);
        exp_q = {6'h3F, 6'h3F, 6'h3F, 6'h03};
        check_chunks("pad chunks", q20, exp_q);
        check("pad done pulses", done20, 1);

        // Busy rejection
        q18.delete();
        done18 = 0;
        start18(18'h2A5C3);
        wait_chunks18(2, "busy");
        bus18.data_in = 18'h3FFFF;
        bus18.send    = 1'b1;
        @(negedge clk);
        bus18.send    = 1'b0;
        wait_done18("busy");
        repeat (40) @(negedge clk);
        exp_q = {6'h03, 6'h17, 6'h2A};
        check_chunks("busy chunks", q18, exp_q);
        check("busy done pulses", done18, 1);
        check("busy ready", bus18.ready, 1'b1);

        // Timeout with ack held low
        q18.delete();
        done18 = 0;
        err18  = 0;
        ack_en = 1'b0;
        start18(18'h2A5C3);
        k = 0;
        while (!bus18.wire_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("to req rose", bus18.wire_req, 1'b1);
        lat = 0;
        while (!bus18.error && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("to error delay", lat, 50);
        check("to req low", bus18.wire_req, 1'b0);
        check("to ready", bus18.ready, 1'b1);
        check("to data", bus18.wire_data_deliver, 6'h00);
        @(negedge clk);
        check("to error one cycle", bus18.error, 1'b0);
        check("to error pulses", err18, 1);
        check("to no done", done18, 0);
        ack_en = 1'b1;
        repeat (6) @(negedge clk);

        // Async reset while waiting for ack on chunk 2
        q18.delete();
        start18(18'h2A5C3);
        wait_chunks18(3, "rst mid");
        check("rst mid req was high", bus18.wire_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst mid req", bus18.wire_req, 1'b0);
        check("rst mid data", bus18.wire_data_deliver, 6'h00);
        check("rst mid ready", bus18.ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        q18.delete();
        done18 = 0;
        start18(18'h00001);
        wait_done18("post rst");
        @(negedge clk);
        exp_q = {6'h01, 6'h00, 6'h00};
        check_chunks("post rst chunks", q18, exp_q);
        check("post rst done pulses", done18, 1);

        // Back-to-back with send held high
        q18.delete();
        done18    = 0;
        ackviol18 = 0;
        @(negedge clk);
        bus18.data_in = 18'h2A5C3;
        bus18.send    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus18.data_in = 18'h12345;
        check("b2b first accepted", bus18.ready, 1'b0);
        wait_done18("b2b first");
        check("b2b ready with done", bus18.ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("b2b second accepted", bus18.ready, 1'b0);
        bus18.send = 1'b0;
        wait_done18("b2b second");
        @(negedge clk);
        exp_q = {6'h03, 6'h17, 6'h2A, 6'h05, 6'h0D, 6'h12};
        check_chunks("b2b chunks", q18, exp_q);
        check("b2b done pulses", done18, 2);
        check("b2b req before ack low", ackviol18, 0);
        check("data stable while req", unstable18, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
